// File: rtl/ram_access_ctrl_if.sv
// Requester/RAM-strobe bundle for ram_access_ctrl: two requester ports plus RAM control strobes.
// The controller uses the slave modport; the requester/RAM side uses master.
interface ram_access_ctrl_if #(
    parameter int WORD_W = 8,
    parameter int OP_W   = 3
);
    localparam int AW = WORD_W - OP_W;

    logic              req0, req1;
    logic              we0, we1;
    logic [AW-1:0]     addr0, addr1;
    logic [WORD_W-1:0] wdata0, wdata1;
    logic              ack0, ack1;
    logic [WORD_W-1:0] rdata;
    logic              err;
    logic              busy;
    logic              load_MAR, load_MDR, CS, R_NW, MDR_bus;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata, err, busy, load_MAR, load_MDR, CS, R_NW, MDR_bus
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata, err, busy, load_MAR, load_MDR, CS, R_NW, MDR_bus
    );
endinterface

// File: rtl/ram_access_ctrl.sv
// Two-requester round-robin RAM access sequencer driving MAR/MDR/CS strobes over a shared sysbus.
// Optional macro RAM_ADDR_CHECK_EN rejects accesses outside the RAM region (address MSB clear).
module ram_access_ctrl #(
    parameter int WORD_W = 8,
    parameter int OP_W   = 3
) (
    input  logic              clock,
    input  logic              n_reset,
    ram_access_ctrl_if.slave  bus,
    inout  wire  [WORD_W-1:0] sysbus
);
    localparam int AW = WORD_W - OP_W;

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, ACCESS, RDATA, DONE} state_t;

    state_t            state_q, state_d;
    logic              we_q, id_q, last_q;
    logic [AW-1:0]     addr_q;
    logic [WORD_W-1:0] wdata_q, rdata_q;

    logic              grant_valid, grant_id, grant_we, grant_bad;
    logic [AW-1:0]     grant_addr;
    logic [WORD_W-1:0] grant_wdata;
    logic              bus_oe;
    logic [WORD_W-1:0] bus_val;
`ifdef RAM_ADDR_CHECK_EN
    logic              err_q;
`endif

    // On a tie the requester not served last wins.
    always_comb begin
        grant_valid = bus.req0 | bus.req1;
        grant_id    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
        grant_we    = grant_id ? bus.we1    : bus.we0;
        grant_addr  = grant_id ? bus.addr1  : bus.addr0;
        grant_wdata = grant_id ? bus.wdata1 : bus.wdata0;
    end

`ifdef RAM_ADDR_CHECK_EN
    assign grant_bad = ~grant_addr[AW-1];
`else
    assign grant_bad = 1'b0;
`endif

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d      = state_q;
        bus.load_MAR = 1'b0;
        bus.load_MDR = 1'b0;
        bus.CS       = 1'b0;
        bus.R_NW     = 1'b0;
        bus.MDR_bus  = 1'b0;
        bus.ack0     = 1'b0;
        bus.ack1     = 1'b0;
        bus.err      = 1'b0;
        bus.busy     = (state_q != IDLE);
        bus_oe       = 1'b0;
        bus_val      = '0;
        case (state_q)
            IDLE:   if (grant_valid) state_d = grant_bad ? DONE : ADDR;
            ADDR: begin
                state_d      = we_q ? WDATA : ACCESS;
                bus.load_MAR = 1'b1;
                bus_oe       = 1'b1;
                bus_val      = {{OP_W{1'b0}}, addr_q};
            end
            WDATA: begin
                state_d      = ACCESS;
                bus.load_MDR = 1'b1;
                bus_oe       = 1'b1;
                bus_val      = wdata_q;
            end
            ACCESS: begin
                state_d  = we_q ? DONE : RDATA;
                bus.CS   = 1'b1;
                bus.R_NW = ~we_q;
            end
            RDATA: begin
                state_d     = DONE;
                bus.MDR_bus = 1'b1;
            end
            DONE: begin
                state_d  = IDLE;
                bus.ack0 = ~id_q;
                bus.ack1 = id_q;
`ifdef RAM_ADDR_CHECK_EN
                bus.err  = err_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign sysbus    = bus_oe ? bus_val : {WORD_W{1'bz}};
    assign bus.rdata = rdata_q;

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            // NOTE: every register here is reset, including the latched operands, so no X leaks onto sysbus.
            state_q <= IDLE;
            we_q    <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef RAM_ADDR_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && grant_valid) begin
                we_q    <= grant_we;
                id_q    <= grant_id;
                last_q  <= grant_id;
                addr_q  <= grant_addr;
                wdata_q <= grant_wdata;
`ifdef RAM_ADDR_CHECK_EN
                err_q   <= grant_bad;
`endif
            end
            if (state_q == RDATA) rdata_q <= sysbus;
        end
    end
endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: directed scenarios then randomized traffic, checked
// per cycle against a transaction-level reference model (expected memory, rdata, arbitration).
module tb_ram_access_ctrl;
    localparam int WORD_W = 8;
    localparam int OP_W   = 3;
`ifdef RAM_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef enum int {P_IDLE, P_ADDR, P_WDATA, P_ACCESS, P_RDATA, P_DONE} phase_t;

    logic      clock;
    logic      n_reset;
    wire [7:0] sysbus;

    ram_access_ctrl_if #(.WORD_W(WORD_W), .OP_W(OP_W)) bus ();

    ram_access_ctrl #(.WORD_W(WORD_W), .OP_W(OP_W)) dut (
        .clock  (clock),
        .n_reset(n_reset),
        .bus    (bus),
        .sysbus (sysbus)
    );

    int checks = 0;
    int errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // RAM environment: MAR/MDR plus storage reacting to the strobes.
    logic [4:0]  mar     = '0;
    logic [7:0]  mdr     = '0;
    logic [7:0]  ram_mem [32];
    logic [31:0] ram_vld = '0;
    logic        probe_en  = 1'b0;
    logic [7:0]  probe_val = '0;

    function automatic logic [7:0] init_word(input logic [4:0] a);
        return 8'(32'(a) * 37 + 11);
    endfunction

    always @(posedge clock) begin
        if (bus.load_MAR) mar <= sysbus[4:0];
        if (bus.load_MDR) mdr <= sysbus;
        if (bus.CS) begin
            if (bus.R_NW) mdr <= ram_vld[mar] ? ram_mem[mar] : init_word(mar);
            else begin
                ram_mem[mar] <= mdr;
                ram_vld[mar] <= 1'b1;
            end
        end
    end

    assign sysbus = bus.MDR_bus ? mdr : 8'hzz;
    // Probe driver: when the controller must float sysbus, the probe value must read back intact.
    assign sysbus = probe_en ? probe_val : 8'hzz;

    // Reference model
    logic [7:0] ref_mem [32];
    logic [7:0] exp_rdata;
    bit         last_served;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input bit id, input bit we, input logic [4:0] a, input logic [7:0] d);
        if (id) begin
            bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end
    endtask

    task automatic cycle_check(input string tag, input phase_t ph, input bit g, input bit we,
                               input logic [4:0] a, input logic [7:0] d, input bit bad);
        logic [4:0] es;
        logic [1:0] ea;
        probe_en  = (ph == P_IDLE) || (ph == P_ACCESS) || (ph == P_DONE);
        probe_val = 8'($urandom);
        #1;
        case (ph)
            P_ADDR:   es = 5'b10000;
            P_WDATA:  es = 5'b01000;
            P_ACCESS: es = {2'b00, 1'b1, ~we, 1'b0};
            P_RDATA:  es = 5'b00001;
            default:  es = 5'b00000;
        endcase
        ea = (ph == P_DONE) ? (g ? 2'b10 : 2'b01) : 2'b00;
        check($sformatf("%s.strobes", tag),
              32'({bus.load_MAR, bus.load_MDR, bus.CS, bus.R_NW, bus.MDR_bus}), 32'(es));
        check($sformatf("%s.busy", tag), 32'(bus.busy), 32'(ph != P_IDLE));
        check($sformatf("%s.ack", tag), 32'({bus.ack1, bus.ack0}), 32'(ea));
        check($sformatf("%s.err", tag), 32'(bus.err), 32'((ph == P_DONE) && bad));
        case (ph)
            P_ADDR:  check($sformatf("%s.sysbus", tag), 32'(sysbus), 32'({3'b000, a}));
            P_WDATA: check($sformatf("%s.sysbus", tag), 32'(sysbus), 32'(d));
            P_RDATA: check($sformatf("%s.sysbus", tag), 32'(sysbus), 32'(ref_mem[a]));
            default: check($sformatf("%s.sysbus_z", tag), 32'(sysbus), 32'(probe_val));
        endcase
    endtask

    // One IDLE cycle (raising the requested reqs), then the granted transaction, if any.
    task automatic run_txn(input string tag, input bit s0, input bit s1, input bit scramble,
                           input int abort_idx);
        bit         g, we, bad;
        logic [4:0] a;
        logic [7:0] d;
        phase_t     seq[$];
        @(posedge clock); #1;
        if (s0) bus.req0 = 1'b1;
        if (s1) bus.req1 = 1'b1;
        cycle_check({tag, ".idle"}, P_IDLE, 1'b0, 1'b0, 5'h0, 8'h0, 1'b0);
        check({tag, ".rdata_idle"}, 32'(bus.rdata), 32'(exp_rdata));
        if (!bus.req0 && !bus.req1) return;

        if (bus.req0 && bus.req1) g = (last_served == 1'b1) ? 1'b0 : 1'b1;
        else                      g = bus.req1;
        last_served = g;
        we  = g ? bus.we1    : bus.we0;
        a   = g ? bus.addr1  : bus.addr0;
        d   = g ? bus.wdata1 : bus.wdata0;
        bad = CHECK_EN && !a[4];
        if (bad)     seq.push_back(P_DONE);
        else if (we) begin
            seq.push_back(P_ADDR); seq.push_back(P_WDATA);
            seq.push_back(P_ACCESS); seq.push_back(P_DONE);
        end else begin
            seq.push_back(P_ADDR); seq.push_back(P_ACCESS);
            seq.push_back(P_RDATA); seq.push_back(P_DONE);
        end

        foreach (seq[i]) begin
            @(posedge clock); #1;
            if (scramble && i == 0) begin
                set_op(1'b0, 1'($urandom), 5'($urandom), 8'($urandom));
                set_op(1'b1, 1'($urandom), 5'($urandom), 8'($urandom));
            end
            if (seq[i] == P_DONE && !bad) begin
                if (we) ref_mem[a] = d;
                else    exp_rdata  = ref_mem[a];
            end
            cycle_check($sformatf("%s.c%0d", tag, i + 1), seq[i], g, we, a, d, bad);
            if (seq[i] == P_DONE) begin
                check({tag, ".rdata"}, 32'(bus.rdata), 32'(exp_rdata));
                if (g) bus.req1 = 1'b0;
                else   bus.req0 = 1'b0;
            end
            if (i == abort_idx) begin
                n_reset   = 1'b0;
                probe_en  = 1'b1;
                probe_val = 8'($urandom);
                exp_rdata = 8'h00;
                #1;
                check({tag, ".rst_strobes"}, 32'({bus.load_MAR, bus.load_MDR, bus.CS, bus.R_NW,
                      bus.MDR_bus}), 32'h0);
                check({tag, ".rst_busy"}, 32'(bus.busy), 32'h0);
                check({tag, ".rst_ack"}, 32'({bus.ack1, bus.ack0, bus.err}), 32'h0);
                check({tag, ".rst_sysbus_z"}, 32'(sysbus), 32'(probe_val));
                check({tag, ".rst_rdata"}, 32'(bus.rdata), 32'(exp_rdata));
                bus.req0    = 1'b0;
                bus.req1    = 1'b0;
                last_served = 1'b1;
                repeat (2) @(posedge clock);
                #3 n_reset = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(posedge clock); #1;
                    cycle_check($sformatf("%s.post%0d", tag, k), P_IDLE, 1'b0, 1'b0, 5'h0, 8'h0, 1'b0);
                end
                return;
            end
        end
    endtask

    initial begin
        n_reset  = 1'b0;
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        set_op(1'b0, 1'b0, 5'h0, 8'h0);
        set_op(1'b1, 1'b0, 5'h0, 8'h0);
        for (int i = 0; i < 32; i++) ref_mem[i] = init_word(5'(i));
        last_served = 1'b1;
        exp_rdata   = 8'h00;
        probe_en    = 1'b1;
        probe_val   = 8'h5A;
        #2;
        check("reset.busy", 32'(bus.busy), 32'h0);
        check("reset.strobes", 32'({bus.load_MAR, bus.load_MDR, bus.CS, bus.R_NW, bus.MDR_bus}), 32'h0);
        check("reset.ack_err", 32'({bus.ack1, bus.ack0, bus.err}), 32'h0);
        check("reset.rdata", 32'(bus.rdata), 32'h0);
        check("reset.sysbus_z", 32'(sysbus), 32'h5A);
        #10 n_reset = 1'b1;

        // Write A5 to 0x13 from requester 0, then read it back from requester 1.
        set_op(1'b0, 1'b1, 5'h13, 8'hA5);
        run_txn("wr_a5", 1'b1, 1'b0, 1'b0, -1);
        set_op(1'b1, 1'b0, 5'h13, 8'h00);
        run_txn("rd_a5", 1'b0, 1'b1, 1'b0, -1);
        check("rd_a5.value", 32'(bus.rdata), 32'hA5);

        // Reset during ACCESS of a write, then during ADDR of a read.
        set_op(1'b0, 1'b1, 5'h1C, 8'h3C);
        run_txn("rst_access", 1'b1, 1'b0, 1'b0, 2);
        set_op(1'b1, 1'b0, 5'h13, 8'h00);
        run_txn("rst_addr", 1'b0, 1'b1, 1'b0, 0);

        // Ties after reset: 0 first, then pending 1, then the next tie goes to 0.
        set_op(1'b0, 1'b1, 5'h11, 8'h11);
        set_op(1'b1, 1'b1, 5'h12, 8'h22);
        run_txn("tie_a", 1'b1, 1'b1, 1'b0, -1);
        run_txn("tie_b", 1'b0, 1'b0, 1'b0, -1);
        run_txn("tie_c", 1'b1, 1'b1, 1'b0, -1);
        run_txn("tie_d", 1'b0, 1'b0, 1'b0, -1);
        run_txn("idle", 1'b0, 1'b0, 1'b0, -1);

        // Access outside the RAM region.
        set_op(1'b0, 1'b0, 5'h03, 8'h00);
        run_txn("low_rd", 1'b1, 1'b0, 1'b0, -1);
        set_op(1'b1, 1'b1, 5'h05, 8'h77);
        run_txn("low_wr", 1'b0, 1'b1, 1'b0, -1);

        for (int n = 0; n < 40; n++) begin
            set_op(1'b0, 1'($urandom), 5'($urandom), 8'($urandom));
            set_op(1'b1, 1'($urandom), 5'($urandom), 8'($urandom));
            run_txn($sformatf("rnd%0d", n), 1'($urandom), 1'($urandom), 1'b1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/ram_access_ctrl.md
RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 Parameter WORD_W, default 8, system bus and data word width.
REQ-002 Parameter OP_W, default 3, opcode width; address width AW = WORD_W-OP_W; RAM region = address MSB set.
REQ-003 clock  input  1  system clock, all state on rising edge.
REQ-004 n_reset  input  1  asynchronous active-low reset.
REQ-005 req0 / req1  input  1  access request from requester 0 / 1; held high until matching ack.
REQ-006 we0 / we1  input  1  1 = write, 0 = read; sampled at grant.
REQ-007 addr0 / addr1  input  AW  word address; sampled at grant.
REQ-008 wdata0 / wdata1  input  WORD_W  write data; sampled at grant.
REQ-009 ack0 / ack1  output  1  one-cycle completion pulse to requester 0 / 1.
REQ-010 rdata  output  WORD_W  last read data, shared by both requesters.
REQ-011 err  output  1  one-cycle rejected-access pulse, concurrent with ack.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 load_MAR, load_MDR, CS, R_NW, MDR_bus  output  1 each  RAM control strobes.
REQ-014 sysbus  inout  WORD_W  shared system bus; driven only as stated in REQ-020, else high-impedance.

Function
REQ-015 FSM states: IDLE, ADDR, WDATA, ACCESS, RDATA, DONE; one state per cycle outside IDLE.
REQ-016 IDLE: no request -> stay; request(s) -> grant, latch granted we/addr/wdata and requester id, go ADDR.
REQ-017 Arbitration round-robin: one request -> granted; both -> requester not served last; after reset requester 0 wins first tie.
REQ-018 Write path: ADDR -> WDATA -> ACCESS -> DONE; ack in 4th cycle after grant edge.
REQ-019 Read path: ADDR -> ACCESS -> RDATA -> DONE; ack in 4th cycle after grant edge.
REQ-020 ADDR: sysbus = latched addr zero-extended to WORD_W, load_MAR=1; WDATA: sysbus = latched wdata, load_MDR=1.
REQ-021 ACCESS: CS=1, R_NW = ~latched we; sysbus high-impedance.
REQ-022 RDATA: MDR_bus=1, sysbus high-impedance; rdata <= sysbus on the edge leaving RDATA.
REQ-023 DONE: ack of latched requester = 1 for exactly one cycle, then IDLE; rdata held until next read completes.
REQ-024 All RAM strobes 0 in any state not naming them; never two strobes of load_MAR/load_MDR/CS/MDR_bus high together.
REQ-025 Request inputs ignored outside IDLE; req seen high in IDLE after DONE is a new request.
REQ-026 Requester changing we/addr/wdata after grant has no effect on the in-flight access.

Reset
REQ-027 n_reset low: state IDLE, all strobes/ack/err/busy 0, rdata 0, round-robin pointer = requester 1 last served, sysbus high-impedance, immediately.
REQ-028 Reset mid-operation discards the in-flight access; no ack is issued for it.

Configuration
REQ-029 Macro RAM_ADDR_CHECK_EN defined: grant with latched addr MSB = 0 goes IDLE -> DONE, ack and err pulse together in 1st cycle after grant, no strobe asserted, sysbus not driven, rdata unchanged.
REQ-030 Macro RAM_ADDR_CHECK_EN undefined: every request takes the full path of REQ-018/019 regardless of address; err tied 0.

Verification
REQ-031 req0, we0=1, addr0=5'h13, wdata0=8'hA5 -> ADDR sysbus=8'h13 load_MAR, WDATA sysbus=8'hA5 load_MDR, ACCESS CS=1 R_NW=0, ack0 4th cycle.
REQ-032 Then req1, we1=0, addr1=5'h13 -> ACCESS CS=1 R_NW=1, RDATA MDR_bus=1, ack1 4th cycle, rdata=8'hA5.
REQ-033 After reset req0 and req1 high same cycle -> requester 0 served first, requester 1 granted in IDLE following ack0; next tie -> requester 0.
REQ-034 n_reset low during ACCESS of a write -> strobes 0 same cycle, no ack, state IDLE, sysbus high-impedance.
REQ-035 RAM_ADDR_CHECK_EN defined, req0 read addr0=5'h03 -> ack0 and err high 1st cycle after grant, CS never high, rdata unchanged; undefined -> full 4-cycle read, err 0.
REQ-036 Every scenario: sysbus high-impedance in IDLE/ACCESS/RDATA/DONE, busy low only in IDLE.
